// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier that borrows an external ALU's adder.
// Consumes one multiplier bit per cycle and reports the low WIDTH product bits with unsigned overflow.
module alu_mul_seq #(
    parameter int          WIDTH      = 16,
    parameter logic [3:0]  ALU_ADD_OP = 4'd2,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_R,
    output logic [WIDTH-1:0] product,
    output logic             ovfl_out,
    output logic             isZero,
    output logic             busy,
    output logic             done
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0] mc_q,      mc_d;
    logic [WIDTH-1:0] mp_q,      mp_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic             lost_q,    lost_d;
    logic             ov_q,      ov_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             ovfl_q,    ovfl_d;
    logic             is_zero_q, is_zero_d;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        acc_d     = acc_q;
        mc_d      = mc_q;
        mp_d      = mp_q;
        cnt_d     = cnt_q;
        lost_d    = lost_q;
        ov_d      = ov_q;
        product_d = product_q;
        ovfl_d    = ovfl_q;
        is_zero_d = is_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mc_d    = mcand;
                    mp_d    = mplier;
                    acc_d   = '0;
                    lost_d  = 1'b0;
                    ov_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A wrap of the sum, or adding after a set multiplicand bit fell off the top, means product >= 2^WIDTH.
                if (mp_q[0]) begin
                    acc_d = alu_R;
                    ov_d  = ov_q | (alu_R < acc_q) | lost_q;
                end
                mc_d   = mc_q << 1;
                lost_d = lost_q | mc_q[WIDTH-1];
                mp_d   = mp_q >> 1;
                cnt_d  = cnt_q + 1'b1;
                // Results are registered on entry to DONE so they are already valid while done is high.
                if ((cnt_q == LAST_CNT) || (EARLY_EXIT && (mp_d == '0))) begin
                    state_d   = S_DONE;
                    product_d = acc_d;
                    ovfl_d    = ov_d;
                    is_zero_d = (acc_d == '0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mc_q      <= '0;
            mp_q      <= '0;
            cnt_q     <= '0;
            lost_q    <= 1'b0;
            ov_q      <= 1'b0;
            product_q <= '0;
            ovfl_q    <= 1'b0;
            is_zero_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mc_q      <= mc_d;
            mp_q      <= mp_d;
            cnt_q     <= cnt_d;
            lost_q    <= lost_d;
            ov_q      <= ov_d;
            product_q <= product_d;
            ovfl_q    <= ovfl_d;
            is_zero_q <= is_zero_d;
        end
    end

    assign alu_A    = acc_q;
    assign alu_B    = mc_q;
    assign alu_op   = ALU_ADD_OP;
    assign product  = product_q;
    assign ovfl_out = ovfl_q;
    assign isZero   = is_zero_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: directed and random multiplies checked against plain-arithmetic expectations,
// with a behavioural alu16b standing in for the external ALU on both a full-latency and an early-exit instance.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start_ee;
    logic [15:0] mcand, mplier;

    logic [15:0] alu_A, alu_B, alu_R, product;
    logic [3:0]  alu_op;
    logic        ovfl_out, isZero, busy, done;

    logic [15:0] alu_A_ee, alu_B_ee, alu_R_ee, product_ee;
    logic [3:0]  alu_op_ee;
    logic        ovfl_ee, isZero_ee, busy_ee, done_ee;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_mul_seq #(.WIDTH(16), .ALU_ADD_OP(4'd2), .EARLY_EXIT(1'b0)) dut (
        .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_R(alu_R),
        .product(product), .ovfl_out(ovfl_out), .isZero(isZero), .busy(busy), .done(done)
    );

    alu_mul_seq #(.WIDTH(16), .ALU_ADD_OP(4'd2), .EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .reset(reset), .start(start_ee), .mcand(mcand), .mplier(mplier),
        .alu_A(alu_A_ee), .alu_B(alu_B_ee), .alu_op(alu_op_ee), .alu_R(alu_R_ee),
        .product(product_ee), .ovfl_out(ovfl_ee), .isZero(isZero_ee), .busy(busy_ee), .done(done_ee)
    );

    function automatic logic [15:0] alu16b(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a - b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return ~(a & b);
            4'd7:    return ~a;
            default: return '0;
        endcase
    endfunction

    assign alu_R    = alu16b(alu_A, alu_B, alu_op);
    assign alu_R_ee = alu16b(alu_A_ee, alu_B_ee, alu_op_ee);

    function automatic logic [31:0] full_prod(input logic [15:0] a, input logic [15:0] b);
        return {16'h0, a} * {16'h0, b};
    endfunction

    // Cycles from accept to done: one per multiplier bit processed, plus the DONE cycle.
    function automatic int ref_latency(input bit ee, input logic [15:0] b);
        int bits;
        if (!ee) return 17;
        bits = 1;
        for (int i = 0; i < 16; i++)
            if (b[i]) bits = i + 1;
        return bits + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".product"}, product, 0);
        check({tag, ".ovfl"}, ovfl_out, 0);
        check({tag, ".isZero"}, isZero, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".alu_op"}, alu_op, 2);
        check({tag, ".alu_A"}, alu_A, 0);
        check({tag, ".alu_B"}, alu_B, 0);
        check({tag, ".ee_busy"}, busy_ee, 0);
        check({tag, ".ee_isZero"}, isZero_ee, 1);
    endtask

    task automatic launch(input bit ee, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        mcand  = a;
        mplier = b;
        if (ee) start_ee = 1'b1; else start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        start_ee = 1'b0;
        mcand    = 16'($urandom);
        mplier   = 16'($urandom);
    endtask

    task automatic wait_done(input bit ee, input int cyc_in, output int cyc);
        cyc = cyc_in;
        while (!(ee ? done_ee : done) && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_result(input bit ee, input logic [15:0] a, input logic [15:0] b,
                                input int cyc, input string tag);
        logic [31:0] p;
        p = full_prod(a, b);
        check({tag, ".latency"}, cyc, ref_latency(ee, b));
        check({tag, ".product"}, ee ? product_ee : product, p[15:0]);
        check({tag, ".ovfl"}, ee ? ovfl_ee : ovfl_out, (p >= 32'h1_0000) ? 1 : 0);
        check({tag, ".isZero"}, ee ? isZero_ee : isZero, (p[15:0] == 16'h0) ? 1 : 0);
        check({tag, ".busy"}, ee ? busy_ee : busy, 1);
        @(negedge clk);
        check({tag, ".done_pulse"}, ee ? done_ee : done, 0);
        check({tag, ".held"}, ee ? product_ee : product, p[15:0]);
    endtask

    task automatic run_mul(input bit ee, input logic [15:0] a, input logic [15:0] b, input string tag);
        int cyc;
        launch(ee, a, b);
        wait_done(ee, 1, cyc);
        check_result(ee, a, b, cyc, tag);
    endtask

    initial begin
        int cyc;
        bit saw_done;
        logic [15:0] ra, rb;

        reset    = 1'b0;
        start    = 1'b0;
        start_ee = 1'b0;
        mcand    = '0;
        mplier   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("reset");

        run_mul(0, 16'd3, 16'd5, "mul_3x5");
        run_mul(0, 16'h6000, 16'd3, "carry");
        run_mul(0, 16'h00FF, 16'h0101, "ffff");
        run_mul(0, 16'h0100, 16'h0100, "lost_bit");
        run_mul(0, 16'hFFFF, 16'd1, "ffff_x1");
        run_mul(0, 16'd0, 16'hBEEF, "zero_a");
        run_mul(0, 16'hBEEF, 16'd0, "zero_b");
        run_mul(0, 16'hFFFF, 16'hFFFF, "max_sq");
        run_mul(0, 16'h8000, 16'h8000, "top_bits");

        // Re-pulsed start during RUN must be dropped, not queued.
        launch(0, 16'd2, 16'd3);
        repeat (4) @(negedge clk);
        mcand  = 16'd7;
        mplier = 16'd7;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, 6, cyc);
        check_result(0, 16'd2, 16'd3, cyc, "restart_ignored");
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            saw_done = saw_done | done | busy;
        end
        check("restart_not_queued", saw_done, 0);

        // Reset mid-RUN aborts with no done pulse.
        launch(0, 16'h1234, 16'h5678);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("reset_mid_run");
        reset = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        check("abort_no_done", saw_done, 0);
        check("abort_idle", busy, 0);

        run_mul(1, 16'd9, 16'd2, "ee_9x2");
        run_mul(1, 16'd5, 16'd0, "ee_zero");
        run_mul(1, 16'h1234, 16'h8000, "ee_top");
        run_mul(1, 16'h0100, 16'h0100, "ee_lost");

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 4 == 1) rb = rb >> $urandom_range(15, 4);
            if (i % 4 == 2) ra = ra >> $urandom_range(15, 4);
            run_mul(0, ra, rb, $sformatf("rand%0d", i));
            run_mul(1, ra, rb >> $urandom_range(15, 0), $sformatf("rand_ee%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Iterative shift-add unsigned multiplier that acts as a requester of the ALU interface.
- Drives A, B and op into an external combinational alu16b instance and consumes its R output.
- Lets the datapath multiply without a dedicated 16x16 array. Sits beside the ALU in the execute stage.
- Reports busy/done, the low 16 bits of the product, and unsigned-overflow and zero flags.

Parameters:
WIDTH, 16, operand/result width; must equal the ALU width
ALU_ADD_OP, 4'd2, ALU op code for ADD (0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 NOR, 6 NAND, 7 INV)
EARLY_EXIT, 0, 1 = leave RUN as soon as the remaining multiplier is zero

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-low; one clock, reset sampled on rising edge, low = reset
start  in  1  request pulse; sampled only in IDLE
mcand  in  WIDTH  multiplicand; captured when start accepted
mplier  in  WIDTH  multiplier; captured when start accepted
alu_A  out  WIDTH  to ALU A; = acc register
alu_B  out  WIDTH  to ALU B; = shifted multiplicand register
alu_op  out  4  to ALU op; constant ALU_ADD_OP
alu_R  in  WIDTH  from ALU R (combinational, same cycle)
product  out  WIDTH  low WIDTH bits of mcand*mplier; held until next accepted start
ovfl_out  out  1  1 if true product >= 2^WIDTH
isZero  out  1  product == 0 (valid with done and afterwards)
busy  out  1  1 in RUN and DONE
done  out  1  one-cycle pulse when product is valid

Behaviour:
- Reset (reset==0 at edge): state=IDLE; acc, mc, mp, cnt, product cleared; ovfl_out=0, busy=0, done=0. isZero=1.
- Reset wins over every other input. Reset mid-RUN aborts the multiply, and no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE: on start=1, load mc<=mcand, mp<=mplier, acc<=0, lost<=0, ov<=0, cnt<=0, then go to RUN. start=0 stays in IDLE.
- RUN, each cycle (one multiplier bit per cycle):
  - if mp[0]: acc<=alu_R; carry = (alu_R < acc, unsigned); ov<=ov | carry | lost.
  - mc<=mc<<1; lost<=lost | mc[WIDTH-1]; mp<=mp>>1; cnt<=cnt+1.
- Leaving RUN: go to DONE after the cycle with cnt==WIDTH-1. With EARLY_EXIT=1, also leave after any cycle where the next mp value (mp>>1) is 0.
- DONE (one cycle): product<=acc, ovfl_out<=ov, isZero<=(acc==0), done=1, busy=1. Next state is IDLE.
- Latency (EARLY_EXIT=0): start accepted at edge N; done high in cycle N+WIDTH+1, i.e. 17 cycles for WIDTH=16.
- Next start is accepted one cycle after done.
- start asserted while busy is ignored; it is not queued.
- mcand/mplier changes after acceptance have no effect.
- alu_op is always ALU_ADD_OP. ALU outputs other than R (ovfl, isZero, isNegative) are unused, because signed overflow is meaningless here.
- Overflow detection is unsigned only:
  - carry out of an accumulate, or
  - an accumulate while any set multiplicand bit has already been shifted out (lost).
- Wrap-around: product is always the true product mod 2^WIDTH.
- Zero operand: 0*x or x*0 gives product=0, isZero=1, ovfl_out=0, with full latency when EARLY_EXIT=0.

Test Plan:
- reset=0 for 2 cycles, then reset=1 -> busy=0, done=0, product=0, ovfl_out=0, isZero=1, alu_op=2.
- mcand=3, mplier=5, pulse start -> done exactly 17 cycles after accept; product=0x000F, ovfl_out=0, isZero=0; product held after done.
- mcand=0x6000, mplier=3 -> product=0x2000, ovfl_out=1 (pure carry case); mcand=0x00FF, mplier=0x0101 -> 0xFFFF, ovfl_out=0.
- mcand=0x0100, mplier=0x0100 -> product=0x0000, ovfl_out=1, isZero=1 (lost-bit case); mcand=0xFFFF, mplier=1 -> 0xFFFF, ovfl_out=0.
- start re-pulsed with 7*7 mid-RUN of a 2*3 op -> 2*3 completes with product=6; the second request is ignored. reset=0 mid-RUN -> IDLE, no done, all outputs at reset values.
- EARLY_EXIT=1, mcand=9, mplier=2 -> done 3 cycles after accept, product=0x0012.
